// File: rtl/arm7tdmi_block_xfer_seq.sv
// ---------------------------------------------------------------------------
// arm7tdmi_block_xfer_seq
//
// Block data transfer sequencer for ARM LDM/STM. The execute stage launches it
// with the decoded P/U/S/W/L bits, the base register (index and value) and the
// 16-bit register list. It then runs one word transfer per listed register
// on the memory bus. Stores read the register file and loads write it. It
// ends with a one-cycle FINISH state that carries the optional base
// writeback. The execute stage stalls while busy_o is high.
//
// Parameters
//   ADDR_WIDTH      width of memory addresses and base/writeback values
//   EMPTY_LIST_R15  1: an empty list transfers R15 only and moves the base by
//                      0x40 (ARMv4 behaviour)
//                   0: an empty list completes with no transfer, no writeback
//
// Optional feature macro: ARM7_LDM_USER_BANK_EN
//   defined   -> S bit drives rf_user_bank_o (user-bank transfer) and
//                spsr_restore_o (LDM with R15 and S: SPSR -> CPSR)
//   undefined -> S bit ignored, both outputs tied low
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               single-cycle launch, ignored while busy_o=1
//   base_addr_i           Rn value, sampled on start
//   base_reg_i            Rn index
//   reg_list_i            instruction bits [15:0]
//   p/u/s/w/l_bit_i       pre-index, up, PSR/user, writeback, load
//   busy_o                high from the cycle after start through FINISH
//   done_o                one-cycle pulse in FINISH
//   pc_load_o             with done_o when a load wrote R15
//   mem_req_o/addr_o/we_o/wdata_o, mem_ready_i/rdata_i   memory handshake
//   rf_raddr_o/rf_rdata_i                      same-cycle register read
//   rf_we_o/waddr_o/wdata_o                    register write
//   rf_user_bank_o                             force user-bank access
//   wb_en_o/wb_data_o                          base writeback
//   spsr_restore_o                             request SPSR -> CPSR copy
// ---------------------------------------------------------------------------
module arm7tdmi_block_xfer_seq #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit EMPTY_LIST_R15 = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [3:0]            base_reg_i,
  input  logic [15:0]           reg_list_i,
  input  logic                  p_bit_i,
  input  logic                  u_bit_i,
  input  logic                  s_bit_i,
  input  logic                  w_bit_i,
  input  logic                  l_bit_i,

  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pc_load_o,

  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [31:0]           mem_rdata_i,

  output logic [3:0]            rf_raddr_o,
  input  logic [31:0]           rf_rdata_i,
  output logic                  rf_we_o,
  output logic [3:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  rf_user_bank_o,

  output logic                  wb_en_o,
  output logic [ADDR_WIDTH-1:0] wb_data_o,
  output logic                  spsr_restore_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] WORD       = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] EMPTY_SPAN = ADDR_WIDTH'(7'h40);

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [4:0] popcount16(input logic [15:0] m);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) begin
      popcount16 = popcount16 + 5'(m[i]);
    end
  endfunction

  // Index of the lowest set bit; scanning downwards lets the lowest one win.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_set = 4'(i);
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                  state_q,     state_d;
  logic [15:0]             mask_q,      mask_d;      // registers still to move
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;      // current transfer address
  logic [ADDR_WIDTH-1:0]   wb_data_q,   wb_data_d;
  logic                    load_q,      load_d;
  logic                    wb_allow_q,  wb_allow_d;
  logic                    pc_load_q,   pc_load_d;
  logic                    user_bank_q, user_bank_d;
  logic                    spsr_q,      spsr_d;

  // -------------------------------------------------------------------------
  // Launch-time decode (only consumed in IDLE on start)
  // -------------------------------------------------------------------------
  logic                  list_empty;
  logic [15:0]           eff_list;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] wb_value;
  logic                  user_bank_start;
  logic                  spsr_start;

  assign list_empty = (reg_list_i == 16'h0000);
  assign eff_list   = (list_empty && EMPTY_LIST_R15) ? 16'h8000 : reg_list_i;
  // An empty list always spans 16 words, regardless of EMPTY_LIST_R15; when
  // that parameter is 0 the span is never used because nothing transfers.
  assign span       = list_empty ? EMPTY_SPAN
                                 : ADDR_WIDTH'({popcount16(reg_list_i), 2'b00});

  // Transfers always run upwards, so descending modes start at the bottom of
  // the block: DA ends at the base, DB ends one word below it.
  always_comb begin
    if (u_bit_i) begin
      start_addr = p_bit_i ? (base_addr_i + WORD) : base_addr_i;
    end else begin
      start_addr = p_bit_i ? (base_addr_i - span) : (base_addr_i - span + WORD);
    end
  end

  assign wb_value = u_bit_i ? (base_addr_i + span) : (base_addr_i - span);

`ifdef ARM7_LDM_USER_BANK_EN
  // LDM with R15 and S restores CPSR and uses the current bank; every other
  // S-form transfers the user-bank registers.
  assign user_bank_start = s_bit_i && !(l_bit_i && eff_list[15]);
  assign spsr_start      = s_bit_i &&  l_bit_i && eff_list[15];
`else
  logic unused_s_bit;
  assign unused_s_bit    = s_bit_i;
  assign user_bank_start = 1'b0;
  assign spsr_start      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wb_data_d   = wb_data_q;
    load_d      = load_q;
    wb_allow_d  = wb_allow_q;
    pc_load_d   = pc_load_q;
    user_bank_d = user_bank_q;
    spsr_d      = spsr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d      = eff_list;
          addr_d      = start_addr;
          wb_data_d   = wb_value;
          load_d      = l_bit_i;
          // A load that includes Rn keeps the loaded value, not the writeback.
          wb_allow_d  = w_bit_i && !(l_bit_i && eff_list[base_reg_i])
                        && (eff_list != 16'h0000);
          pc_load_d   = l_bit_i && eff_list[15];
          user_bank_d = user_bank_start;
          spsr_d      = spsr_start;
          state_d     = (eff_list == 16'h0000) ? ST_FINISH : ST_XFER;
        end
      end

      ST_XFER: begin
        if (mem_ready_i) begin
          // m & (m-1) clears exactly the lowest set bit, i.e. the register
          // that just completed.
          mask_d = mask_q & (mask_q - 16'd1);
          addr_d = addr_q + WORD;
          if ((mask_q & (mask_q - 16'd1)) == 16'h0000) begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst_i) begin
      // NOTE: all state is reset, including the datapath registers, because
      // wb_data_o is visible while idle and must read 0 out of reset.
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      addr_q      <= '0;
      wb_data_q   <= '0;
      load_q      <= 1'b0;
      wb_allow_q  <= 1'b0;
      pc_load_q   <= 1'b0;
      user_bank_q <= 1'b0;
      spsr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wb_data_q   <= wb_data_d;
      load_q      <= load_d;
      wb_allow_q  <= wb_allow_d;
      pc_load_q   <= pc_load_d;
      user_bank_q <= user_bank_d;
      spsr_q      <= spsr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Outputs are qualified with !rst_i so a reset aborts the current transfer
  // in the very cycle it is asserted: no register write or writeback slips out.
  logic       in_xfer;
  logic       in_finish;
  logic [3:0] cur_reg;

  assign in_xfer   = (state_q == ST_XFER)   && !rst_i;
  assign in_finish = (state_q == ST_FINISH) && !rst_i;
  assign cur_reg   = lowest_set(mask_q);

  always_comb begin
    busy_o         = 1'b0;
    done_o         = 1'b0;
    pc_load_o      = 1'b0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_we_o       = 1'b0;
    mem_wdata_o    = '0;
    rf_raddr_o     = '0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    rf_user_bank_o = 1'b0;
    wb_en_o        = 1'b0;
    wb_data_o      = '0;
    spsr_restore_o = 1'b0;

    if (!rst_i) begin
      busy_o    = (state_q != ST_IDLE);
      wb_data_o = wb_data_q;
    end

    if (in_xfer) begin
      mem_req_o      = 1'b1;
      mem_addr_o     = addr_q;
      mem_we_o       = !load_q;
      rf_user_bank_o = user_bank_q;
      if (load_q) begin
        if (mem_ready_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = cur_reg;
          rf_wdata_o = mem_rdata_i;
        end
      end else begin
        rf_raddr_o  = cur_reg;
        mem_wdata_o = rf_rdata_i;
      end
    end

    if (in_finish) begin
      done_o         = 1'b1;
      wb_en_o        = wb_allow_q;
      pc_load_o      = pc_load_q;
      spsr_restore_o = spsr_q;
    end
  end

endmodule

// File: doc/arm7tdmi_block_xfer_seq.md
Name: arm7tdmi_block_xfer_seq

Overview:
Sequencer for ARM LDM/STM (INSTR_BLOCK_DT) instructions. The execute stage starts it with the decoded P/U/S/W/L bits, the base register index and value, and the 16-bit register list. It then issues one word transfer per register on the memory bus, reads the register file for stores and writes it for loads. It finishes with an optional base writeback, and the execute stage stalls while busy is high.

Parameters:
ADDR_WIDTH, 32, width of the memory address and base/writeback values.
EMPTY_LIST_R15, 1, when 1 an empty register list transfers R15 only and adjusts the base by 0x40 (ARMv4 behaviour); when 0 an empty list completes with no transfer and no writeback.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle launch; ignored while busy=1.
base_addr  in  ADDR_WIDTH  value of Rn, sampled on start.
base_reg  in  4  index of Rn.
reg_list  in  16  instruction bits [15:0].
p_bit, u_bit, s_bit, w_bit, l_bit  in  1 each  pre-index, up, PSR/user, writeback, load.
busy  out  1  high from the cycle after an accepted start through the FINISH cycle.
done  out  1  one-cycle pulse in the FINISH state.
pc_load  out  1  pulses with done when a load wrote R15.
mem_req  out  1  transfer request.
mem_addr  out  ADDR_WIDTH  word-aligned transfer address.
mem_we  out  1  1 = store.
mem_wdata  out  32  store data, equal to rf_rdata.
mem_ready  in  1  transfer accepted and completed this cycle.
mem_rdata  in  32  load data, valid when mem_ready=1.
rf_raddr  out  4  register-file read index (combinational from the current register).
rf_rdata  in  32  same-cycle register-file read data.
rf_we  out  1  register-file write strobe.
rf_waddr  out  4  register-file write index.
rf_wdata  out  32  register-file write data.
rf_user_bank  out  1  force user-bank register access.
wb_en  out  1  base writeback strobe.
wb_data  out  ADDR_WIDTH  base writeback value.
spsr_restore  out  1  request copy of SPSR to CPSR.

Behaviour:
- Reset:
  - state goes to IDLE.
  - Every output is 0, including mem_addr, wb_data and rf_*.
  - A reset asserted during a transfer aborts it immediately; no further rf_we or wb_en occurs.
- States:
  - IDLE: on start, latch the inputs, the remaining-register mask and n = popcount(reg_list).
  - XFER: one transfer per handshake.
  - FINISH: one cycle, then return to IDLE.
- Empty list with EMPTY_LIST_R15=1: mask is forced to 0x8000 and the address span is 0x40.
- Empty list with EMPTY_LIST_R15=0: IDLE goes directly to FINISH with wb_en=0.
- Start address, with span = 4n (or 0x40 for an empty list):
  - IA: base
  - IB: base+4
  - DA: base-span+4
  - DB: base-span
- Address order: always ascending, +4 per transfer; the lowest-numbered register uses the lowest address.
- Writeback value: wb_data = u_bit ? base+span : base-span. It is computed on start; arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is allowed.
- XFER handshake:
  - mem_req=1, and mem_addr/mem_we are held stable until mem_ready=1.
  - Current register = lowest set bit of the mask.
  - Stores: rf_raddr = current register and mem_wdata = rf_rdata.
  - Loads: in the mem_ready cycle, rf_we=1, rf_waddr=current register and rf_wdata=mem_rdata.
  - On mem_ready, clear the current bit and add 4 to the address. If the mask becomes empty, go to FINISH.
  - mem_ready while mem_req=0 is ignored.
- FINISH:
  - done=1, busy=1, mem_req=0.
  - wb_en = w_bit AND NOT (l_bit AND base_reg is in the list).
  - pc_load = l_bit AND bit 15 of the effective mask.
- Store with the base register in the list: the stored value is the current register-file value of Rn. Writeback occurs only in FINISH, so this is the original base.
- Latency: FINISH is the cycle after the last handshake. The minimum is n+2 cycles from start to done, with zero wait states.

Optional Feature:
Macro ARM7_LDM_USER_BANK_EN.
- Defined:
  - rf_user_bank=1 during XFER when s_bit=1 and NOT (l_bit=1 with R15 in the list).
  - spsr_restore pulses with done when s_bit, l_bit and R15 are all in effect.
- Undefined: s_bit is ignored, and rf_user_bank and spsr_restore are tied to 0.

Test Plan:
- STMIA: base 0x1000, list 0x000F, W=1, zero-wait memory → mem_addr 0x1000/0x1004/0x1008/0x100C with rf_raddr 0..3 and mem_we=1; done on cycle 6 after start; wb_en=1 with wb_data=0x1010.
- LDMDB: base 0x2000, list 0x8003, W=1 → addresses 0x1FF4/0x1FF8/0x1FFC writing R0, R1, R15; pc_load=1; wb_data=0x1FF4.
- Wait states: STMIB with list 0x0001 and mem_ready held low for 2 cycles → mem_addr=base+4 held for 3 cycles, exactly one handshake, done one cycle later.
- Empty list: LDMIA base 0x3000, W=1, EMPTY_LIST_R15=1 → one load from 0x3000 into R15; wb_data=0x3040; pc_load=1.
- Base in list: LDMIA with base_reg=2, list 0x0004, W=1 → R2 is written with mem_rdata and wb_en=0. The STM equivalent stores the original base and then gets wb_en=1.
- Reset mid-op: rst asserted during the 2nd transfer of a 4-register LDM → the next cycle has all outputs 0 and state IDLE, no further rf_we, and a new start is accepted normally.
